// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/scoreboard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Register address width for a given register count (at least one bit).
    function automatic int ra_w(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

    localparam int NREGS_DEF = 32;
    localparam int RA_W_DEF  = ra_w(NREGS_DEF);

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for long-latency ops: tracks pending destinations,
// the outstanding-op count and a sticky error for stray completions.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int RA_W     = ra_w(NREGS),
    parameter int MAX_LONG = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue,
    input  logic [RA_W-1:0]               issue_rd,
    input  logic                          done,
    input  logic [RA_W-1:0]               done_rd,
    output logic [NREGS-1:0]              busy_vec,
    output logic [$clog2(MAX_LONG+1)-1:0] long_cnt,
    output logic                          full,
    output logic                          sb_err
);

    localparam int CW = $clog2(MAX_LONG + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LONG);

    logic             done_ok;
    logic [NREGS-1:0] busy_nxt;

    // Register 0 is never busy, so a completion for x0 is always rejected.
    assign done_ok = done & busy_vec[done_rd];
    assign full    = (long_cnt == MAX_CNT);

    always_comb begin
        busy_nxt = busy_vec;
        if (done_ok) busy_nxt[done_rd] = 1'b0;
        if (issue)   busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_vec <= '0;
            long_cnt <= '0;
            sb_err   <= 1'b0;
        end else begin
            busy_vec <= busy_nxt;
            if (issue && !done_ok)      long_cnt <= long_cnt + CW'(1);
            else if (!issue && done_ok) long_cnt <= long_cnt - CW'(1);
            if (done && !done_ok)       sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_sb_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/RAW/scoreboard stalls,
// memory-wait freeze, branch flushes and a saturating stall counter.
module hazard_sb_unit
    import hazard_pkg::*;
#(
    parameter int NREGS      = 32,
    parameter int RA_W       = ra_w(NREGS),
    parameter int MAX_LONG   = 2,
    parameter bit FORWARD_EN = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [RA_W-1:0]               rs1_d,
    input  logic [RA_W-1:0]               rs2_d,
    input  logic [RA_W-1:0]               rd_d,
    input  logic                          uses_rs1_d,
    input  logic                          uses_rs2_d,
    input  logic                          reg_write_d,
    input  logic                          long_op_d,
    input  logic [RA_W-1:0]               rs1_e,
    input  logic [RA_W-1:0]               rs2_e,
    input  logic [RA_W-1:0]               rd_e,
    input  logic                          reg_write_e,
    input  logic                          result_src_e_b0,
    input  logic                          pc_src_e,
    input  logic [RA_W-1:0]               rd_m,
    input  logic                          reg_write_m,
    input  logic                          mem_req_m,
    input  logic [RA_W-1:0]               rd_w,
    input  logic                          reg_write_w,
    input  logic                          long_done,
    input  logic [RA_W-1:0]               long_rd,
    input  logic                          mem_ready,
    output logic [1:0]                    forward_a_e,
    output logic [1:0]                    forward_b_e,
    output logic                          stall_f,
    output logic                          stall_d,
    output logic                          stall_e,
    output logic                          stall_m,
    output logic                          flush_d,
    output logic                          flush_e,
    output logic [NREGS-1:0]              busy_vec,
    output logic [$clog2(MAX_LONG+1)-1:0] long_cnt,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic                          sb_err
);

    function automatic fwd_sel_t pick_fwd(input logic [RA_W-1:0] rs);
        if (!FORWARD_EN || rs == '0)     return FWD_RF;
        if (reg_write_m && rs == rd_m)   return FWD_M;
        if (reg_write_w && rs == rd_w)   return FWD_W;
        return FWD_RF;
    endfunction

    logic use1, use2, mem_stall, lw_stall, sb_stall, raw_nofwd, hz, full, issue;

    assign forward_a_e = pick_fwd(rs1_e);
    assign forward_b_e = pick_fwd(rs2_e);

    assign use1      = uses_rs1_d & (rs1_d != '0);
    assign use2      = uses_rs2_d & (rs2_d != '0);
    assign mem_stall = mem_req_m & ~mem_ready;

    assign lw_stall = result_src_e_b0 & (rd_e != '0) &
                      ((uses_rs1_d & (rs1_d == rd_e)) | (uses_rs2_d & (rs2_d == rd_e)));

    assign sb_stall = (uses_rs1_d & busy_vec[rs1_d]) | (uses_rs2_d & busy_vec[rs2_d]) |
                      (reg_write_d & busy_vec[rd_d]) | (long_op_d & full);

    // Without forwarding, any producer still in E or M must drain first.
    assign raw_nofwd = !FORWARD_EN &&
        ((use1 && ((reg_write_e && rs1_d == rd_e) || (reg_write_m && rs1_d == rd_m))) ||
         (use2 && ((reg_write_e && rs2_d == rd_e) || (reg_write_m && rs2_d == rd_m))));

    assign hz = lw_stall | sb_stall | raw_nofwd;

    // A memory wait freezes everything, including a pending branch redirect.
    assign stall_f = mem_stall | (hz & ~pc_src_e);
    assign stall_d = stall_f;
    assign stall_e = mem_stall;
    assign stall_m = mem_stall;
    assign flush_d = ~mem_stall & pc_src_e;
    assign flush_e = ~mem_stall & (pc_src_e | hz);

    assign issue = long_op_d & reg_write_d & (rd_d != '0) & ~stall_d & ~pc_src_e & ~mem_stall;

    reg_scoreboard #(
        .NREGS    (NREGS),
        .RA_W     (RA_W),
        .MAX_LONG (MAX_LONG)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .issue_rd (rd_d),
        .done     (long_done),
        .done_rd  (long_rd),
        .busy_vec (busy_vec),
        .long_cnt (long_cnt),
        .full     (full),
        .sb_err   (sb_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            stall_cnt <= '0;
        else if (stall_d && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_sb_unit.sv
// Bench for hazard_sb_unit: directed scenarios plus randomized traffic checked
// against a reference model, on a forwarding and a non-forwarding instance.
module tb_hazard_sb_unit;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_rd;
    logic uses_rs1_d, uses_rs2_d, reg_write_d, long_op_d, reg_write_e, result_src_e_b0;
    logic pc_src_e, reg_write_m, mem_req_m, reg_write_w, long_done, mem_ready;

    logic [1:0]  fa [2], fb [2], lc [2];
    logic        sf [2], sd [2], se [2], sm [2], fdd [2], fee [2], err [2];
    logic [31:0] bv [2], sc [2];

    int vectors = 0, miscompares = 0;

    // Model state, index 0 = forwarding instance, 1 = no-forwarding instance.
    logic [31:0] bm [2];
    int          scm [2];
    bit          erm [2];

    always #5 clk = ~clk;

    hazard_sb_unit #(.FORWARD_EN(1'b1)) u_fwd (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .reg_write_d(reg_write_d),
        .long_op_d(long_op_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .result_src_e_b0(result_src_e_b0), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_req_m(mem_req_m), .rd_w(rd_w),
        .reg_write_w(reg_write_w), .long_done(long_done), .long_rd(long_rd),
        .mem_ready(mem_ready), .forward_a_e(fa[0]), .forward_b_e(fb[0]),
        .stall_f(sf[0]), .stall_d(sd[0]), .stall_e(se[0]), .stall_m(sm[0]),
        .flush_d(fdd[0]), .flush_e(fee[0]), .busy_vec(bv[0]), .long_cnt(lc[0]),
        .stall_cnt(sc[0]), .sb_err(err[0]));

    hazard_sb_unit #(.FORWARD_EN(1'b0)) u_nofwd (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .reg_write_d(reg_write_d),
        .long_op_d(long_op_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .result_src_e_b0(result_src_e_b0), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_req_m(mem_req_m), .rd_w(rd_w),
        .reg_write_w(reg_write_w), .long_done(long_done), .long_rd(long_rd),
        .mem_ready(mem_ready), .forward_a_e(fa[1]), .forward_b_e(fb[1]),
        .stall_f(sf[1]), .stall_d(sd[1]), .stall_e(se[1]), .stall_m(sm[1]),
        .flush_d(fdd[1]), .flush_e(fee[1]), .busy_vec(bv[1]), .long_cnt(lc[1]),
        .stall_cnt(sc[1]), .sb_err(err[1]));

    task automatic clr;
        {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_rd} = '0;
        {uses_rs1_d, uses_rs2_d, reg_write_d, long_op_d, reg_write_e, result_src_e_b0} = '0;
        {pc_src_e, reg_write_m, mem_req_m, reg_write_w, long_done} = '0;
        mem_ready = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        clr();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic long_issue(input logic [4:0] rd);
        long_op_d = 1'b1; reg_write_d = 1'b1; rd_d = rd;
    endtask

    task automatic test_reset;
        clr();
        reset = 1'b0;
        #3;
        vectors++; if (bv[0] !== 32'h0) begin miscompares++; $display("FAIL reset busy_vec got %h want 0", bv[0]); end
        vectors++; if (lc[0] !== 2'd0) begin miscompares++; $display("FAIL reset long_cnt got %0d want 0", lc[0]); end
        vectors++; if (sc[0] !== 32'd0) begin miscompares++; $display("FAIL reset stall_cnt got %0d want 0", sc[0]); end
        vectors++; if (err[0] !== 1'b0) begin miscompares++; $display("FAIL reset sb_err got %0b want 0", err[0]); end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_forward;
        do_reset();
        rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5; rs2_e = 5;
        #1;
        vectors++; if (fa[0] !== 2'b10) begin miscompares++; $display("FAIL fwd_m_a got %b want 10", fa[0]); end
        vectors++; if (fb[0] !== 2'b10) begin miscompares++; $display("FAIL fwd_m_b got %b want 10", fb[0]); end
        vectors++; if (fa[1] !== 2'b00) begin miscompares++; $display("FAIL nofwd_a got %b want 00", fa[1]); end
        reg_write_m = 0;
        #1;
        vectors++; if (fa[0] !== 2'b01) begin miscompares++; $display("FAIL fwd_w_a got %b want 01", fa[0]); end
        rs1_e = 0; rd_m = 0; reg_write_m = 1; rd_w = 0;
        #1;
        vectors++; if (fa[0] !== 2'b00) begin miscompares++; $display("FAIL fwd_x0 got %b want 00", fa[0]); end
    endtask

    task automatic test_load_use;
        do_reset();
        result_src_e_b0 = 1; rd_e = 6; reg_write_e = 1; uses_rs2_d = 1; rs2_d = 6;
        #1;
        vectors++; if ({sf[0], sd[0], fee[0], fdd[0]} !== 4'b1110) begin miscompares++; $display("FAIL load_use stalls got %b want 1110", {sf[0], sd[0], fee[0], fdd[0]}); end
        tick();
        clr();
        rs2_e = 6; rd_w = 6; reg_write_w = 1;
        #1;
        vectors++; if (fb[0] !== 2'b01) begin miscompares++; $display("FAIL load_use fwd got %b want 01", fb[0]); end
        vectors++; if (sd[0] !== 1'b0) begin miscompares++; $display("FAIL load_use release got %b want 0", sd[0]); end
        vectors++; if (sc[0] !== 32'd1) begin miscompares++; $display("FAIL load_use stall_cnt got %0d want 1", sc[0]); end
    endtask

    task automatic test_long_op;
        do_reset();
        long_issue(7);
        tick();
        vectors++; if (bv[0] !== 32'h80) begin miscompares++; $display("FAIL long busy_set got %h want 80", bv[0]); end
        clr();
        reg_write_d = 1; rd_d = 8; uses_rs1_d = 1; rs1_d = 7;
        for (int c = 0; c < 4; c++) begin
            long_done = (c == 3); long_rd = 7;
            #1;
            vectors++; if ({sd[0], fee[0]} !== 2'b11) begin miscompares++; $display("FAIL long stall c%0d got %b want 11", c, {sd[0], fee[0]}); end
            tick();
        end
        long_done = 0;
        #1;
        vectors++; if (bv[0] !== 32'h0) begin miscompares++; $display("FAIL long busy_clr got %h want 0", bv[0]); end
        vectors++; if (sd[0] !== 1'b0) begin miscompares++; $display("FAIL long issue got %b want 0", sd[0]); end
        vectors++; if (sc[0] !== 32'd4) begin miscompares++; $display("FAIL long stall_cnt got %0d want 4", sc[0]); end
    endtask

    task automatic test_max_long;
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            long_issue(5'(10 + ((c < 2) ? c : 2)));
            long_done = (c == 3); long_rd = 10;
            #1;
            if (c == 2 || c == 3) begin
                vectors++; if (sd[0] !== 1'b1) begin miscompares++; $display("FAIL max_long stall c%0d got %b want 1", c, sd[0]); end
            end
            tick();
            vectors++; if (lc[0] !== want[c]) begin miscompares++; $display("FAIL max_long cnt c%0d got %0d want %0d", c, lc[0], want[c]); end
        end
        vectors++; if (bv[0] !== 32'h1800) begin miscompares++; $display("FAIL max_long busy got %h want 1800", bv[0]); end
    endtask

    task automatic test_mem_stall;
        do_reset();
        mem_req_m = 1; mem_ready = 0; pc_src_e = 1;
        long_issue(4);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if ({sf[0], sd[0], se[0], sm[0], fdd[0], fee[0]} !== 6'b111100) begin miscompares++; $display("FAIL mem_stall c%0d got %b want 111100", c, {sf[0], sd[0], se[0], sm[0], fdd[0], fee[0]}); end
            tick();
        end
        mem_ready = 1;
        #1;
        vectors++; if ({sd[0], se[0], fdd[0], fee[0]} !== 4'b0011) begin miscompares++; $display("FAIL mem_release got %b want 0011", {sd[0], se[0], fdd[0], fee[0]}); end
        vectors++; if (sc[0] !== 32'd3) begin miscompares++; $display("FAIL mem stall_cnt got %0d want 3", sc[0]); end
        vectors++; if (lc[0] !== 2'd0) begin miscompares++; $display("FAIL mem no_issue got %0d want 0", lc[0]); end
    endtask

    task automatic test_err_reset;
        do_reset();
        long_issue(3);
        tick();
        clr();
        long_done = 1; long_rd = 9;
        tick();
        long_done = 0;
        tick();
        vectors++; if (err[0] !== 1'b1) begin miscompares++; $display("FAIL err sticky got %b want 1", err[0]); end
        vectors++; if (bv[0] !== 32'h8 || lc[0] !== 2'd1) begin miscompares++; $display("FAIL err state got %h/%0d want 8/1", bv[0], lc[0]); end
        #2;
        reset = 0;
        #1;
        vectors++; if ({bv[0], lc[0], err[0]} !== 35'h0) begin miscompares++; $display("FAIL async_reset got %h/%0d/%b want 0", bv[0], lc[0], err[0]); end
        tick();
        reset = 1;
    endtask

    function automatic logic [1:0] exp_fwd(input bit fwd, input logic [4:0] rs);
        if (!fwd || rs == 0) return 2'b00;
        if (reg_write_m && rs == rd_m) return 2'b10;
        if (reg_write_w && rs == rd_w) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_random;
        do_reset();
        for (int k = 0; k < 2; k++) begin bm[k] = '0; scm[k] = 0; erm[k] = 0; end
        for (int n = 0; n < 400; n++) begin
            rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
            rd_d  = 5'($urandom_range(0, 7)); rs1_e = 5'($urandom_range(0, 7));
            rs2_e = 5'($urandom_range(0, 7)); rd_e  = 5'($urandom_range(0, 7));
            rd_m  = 5'($urandom_range(0, 7)); rd_w  = 5'($urandom_range(0, 7));
            long_rd = 5'($urandom_range(0, 7));
            uses_rs1_d = 1'($urandom_range(0, 1)); uses_rs2_d = 1'($urandom_range(0, 1));
            reg_write_d = 1'($urandom_range(0, 1)); reg_write_e = 1'($urandom_range(0, 1));
            reg_write_m = 1'($urandom_range(0, 1)); reg_write_w = 1'($urandom_range(0, 1));
            long_op_d = ($urandom_range(0, 2) == 0); result_src_e_b0 = ($urandom_range(0, 3) == 0);
            pc_src_e = ($urandom_range(0, 7) == 0); mem_req_m = ($urandom_range(0, 3) == 0);
            mem_ready = 1'($urandom_range(0, 1)); long_done = ($urandom_range(0, 3) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                bit ms, lw, sb, raw, hz, esd, efd, efe, iss, dok;
                int pop;
                pop = $countones(bm[k]);
                ms  = mem_req_m && !mem_ready;
                lw  = result_src_e_b0 && rd_e != 0 &&
                      ((uses_rs1_d && rs1_d == rd_e) || (uses_rs2_d && rs2_d == rd_e));
                sb  = (uses_rs1_d && bm[k][rs1_d]) || (uses_rs2_d && bm[k][rs2_d]) ||
                      (reg_write_d && bm[k][rd_d]) || (long_op_d && pop == 2);
                raw = (k == 1) &&
                      ((uses_rs1_d && rs1_d != 0 && ((reg_write_e && rs1_d == rd_e) || (reg_write_m && rs1_d == rd_m))) ||
                       (uses_rs2_d && rs2_d != 0 && ((reg_write_e && rs2_d == rd_e) || (reg_write_m && rs2_d == rd_m))));
                hz  = lw || sb || raw;
                esd = ms || (hz && !pc_src_e);
                efd = !ms && pc_src_e;
                efe = !ms && (pc_src_e || hz);
                vectors++;
                if ({fa[k], fb[k], sf[k], sd[k], se[k], sm[k], fdd[k], fee[k]} !==
                    {exp_fwd(k == 0, rs1_e), exp_fwd(k == 0, rs2_e), esd, esd, ms, ms, efd, efe}) begin
                    miscompares++;
                    $display("FAIL rand_comb dut%0d n%0d got %b want %b", k, n,
                             {fa[k], fb[k], sf[k], sd[k], se[k], sm[k], fdd[k], fee[k]},
                             {exp_fwd(k == 0, rs1_e), exp_fwd(k == 0, rs2_e), esd, esd, ms, ms, efd, efe});
                end
                vectors++;
                if ({bv[k], lc[k], err[k], sc[k]} !== {bm[k], 2'(pop), erm[k], 32'(scm[k])}) begin
                    miscompares++;
                    $display("FAIL rand_state dut%0d n%0d got %h/%0d/%b/%0d want %h/%0d/%b/%0d", k, n,
                             bv[k], lc[k], err[k], sc[k], bm[k], pop, erm[k], scm[k]);
                end
                iss = long_op_d && reg_write_d && rd_d != 0 && !esd && !pc_src_e && !ms;
                dok = long_done && bm[k][long_rd];
                if (long_done && !dok) erm[k] = 1'b1;
                if (dok) bm[k][long_rd] = 1'b0;
                if (iss) bm[k][rd_d] = 1'b1;
                if (esd) scm[k]++;
            end
            tick();
        end
    endtask

    initial begin
        clr();
        reset = 1'b1;
        #2;
        test_reset();
        test_forward();
        test_load_use();
        test_long_op();
        test_max_long();
        test_mem_stall();
        test_err_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_sb_unit.md
Name: hazard_sb_unit

Overview:
Parametrised successor to the five-stage hazard unit. Adds a register scoreboard for variable-latency long operations (mul/div unit with a completion pulse). Adds whole-pipe freeze on a data-memory wait (mem_ready handshake), a forwarding-disable mode, an outstanding-op limit and a stall performance counter. Sits beside the controller and datapath in the pipelined core and drives all stall, flush and forward selects.

Parameters:
NREGS, 32, number of architectural registers; x0 is hard-wired zero.
RA_W, $clog2(NREGS), register address width.
MAX_LONG, 2, maximum outstanding long-latency ops (1..NREGS-1).
FORWARD_EN, 1, 1 = M/W forwarding to E; 0 = no forwarding, resolve by stalling.
CNT_W, 32, width of the stall performance counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
rs1_d, rs2_d, rd_d  in  RA_W each  D-stage register fields
uses_rs1_d, uses_rs2_d, reg_write_d, long_op_d  in  1 each  D-stage decode flags
rs1_e, rs2_e, rd_e  in  RA_W each  E-stage register fields
reg_write_e, result_src_e_b0, pc_src_e  in  1 each  E-stage write, load-in-E, branch/jump taken
rd_m  in  RA_W; reg_write_m, mem_req_m  in  1  M-stage info
rd_w  in  RA_W; reg_write_w  in  1  W-stage info
long_done  in  1  long unit wrote long_rd into the register file this cycle
long_rd  in  RA_W  destination of the completing long op
mem_ready  in  1  data memory ready
forward_a_e, forward_b_e  out  2 each  00 regfile, 01 W result, 10 M ALU result
stall_f, stall_d, stall_e, stall_m  out  1 each  hold stage register
flush_d, flush_e  out  1 each  bubble into D/E
busy_vec  out  NREGS  scoreboard state
long_cnt  out  $clog2(MAX_LONG+1)  outstanding long ops
stall_cnt  out  CNT_W  saturating count of cycles with stall_d=1
sb_err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, asynchronous) clears busy_vec, long_cnt, stall_cnt and sb_err. Works mid-operation; pending completions are forgotten. All combinational outputs follow their inputs.
- mem_stall = mem_req_m & ~mem_ready.
  - Forces stall_f, stall_d, stall_e and stall_m to 1 and flush_d and flush_e to 0.
  - The datapath inserts a bubble into W.
  - Highest priority: a taken branch in E is held and resolves after the stall releases.
- Forwarding when FORWARD_EN=1, evaluated per source (forward_a_e from rs1_e, forward_b_e from rs2_e):
  - 10 when rs_e≠0 & rs_e==rd_m & reg_write_m.
  - Else 01 when rs_e≠0 & rs_e==rd_w & reg_write_w.
  - Else 00. M beats W.
- Forwarding when FORWARD_EN=0: both selects are 00. raw_nofwd = used rs_d≠0 matching rd_e (reg_write_e) or rd_m (reg_write_m).
- lw_stall = result_src_e_b0 & rd_e≠0 & rd_e equals any used rs_d.
- sb_stall is any of:
  - busy[rs1_d]&uses_rs1_d
  - busy[rs2_d]&uses_rs2_d
  - reg_write_d & busy[rd_d] (WAW)
  - long_op_d & long_cnt==MAX_LONG
- Stall and flush outputs, when mem_stall is 0:
  - hz = lw_stall | sb_stall | raw_nofwd.
  - stall_f = stall_d = hz & ~pc_src_e; the squashed D instruction never stalls.
  - flush_d = pc_src_e.
  - flush_e = pc_src_e | hz.
  - stall_e = stall_m = 0.
- Issue event = long_op_d & reg_write_d & rd_d≠0 & ~stall_d & ~pc_src_e & ~mem_stall.
  - Sets busy[rd_d] at the next edge.
  - Increments long_cnt.
- Completion: long_done & busy[long_rd] clears busy[long_rd] and decrements long_cnt at the next edge.
  - No same-cycle bypass; a dependent instruction issues one cycle after the clear.
- Issue and completion in the same cycle: the count is unchanged. Both on the same register is impossible by WAW; if it happens, set wins.
- long_done for a non-busy register, or for register 0, is ignored and sets sb_err (sticky until reset).
- busy[0] is always 0.
- stall_cnt increments each cycle stall_d=1 and saturates at all-ones.

Decomposition:
- hazard_pkg holds:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - A RA_W localparam helper.
- One sub-module, reg_scoreboard: busy_vec, long_cnt, set/clear/err logic, parametrised by NREGS and MAX_LONG. The top level holds the combinational hazard logic and stall_cnt.

Test Plan:
- add x5 in M, sub in E reading rs1_e=5 → forward_a_e=10; same with x5 only in W → 01; rs1_e=0 → 00.
- lw x6 in E, D uses rs2_d=6 → one cycle of stall_f=stall_d=1, flush_e=1, stall_cnt=1; next cycle forward_b_e=01.
- mul x7 issues; add reading x7 stalls; long_done with long_rd=7 three cycles later → busy_vec[7] clears on the following edge, add issues the cycle after, stall_cnt=4.
- With MAX_LONG=2: two long ops issue, a third long op in D → stall_d until one long_done; long_cnt goes 0,1,2,1,2.
- mem_req_m=1, mem_ready=0 for 3 cycles with pc_src_e=1 → all four stalls high and flushes low for 3 cycles; then flush_d=flush_e=1.
- long_done with long_rd=9 while not busy → sb_err=1; reset low mid-op → busy_vec=0, long_cnt=0, sb_err=0 immediately.
